// File: rtl/id_stage_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, internal op codes,
// the ID/EX bundle and small decode/forwarding helpers.
package id_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned F3_W   = 3;

  localparam logic [XLEN-1:0] ZERO_WORD = '0;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 5'd0,  OP_ADD  = 5'd1,  OP_SUB  = 5'd2,  OP_SLL  = 5'd3,
    OP_SLT  = 5'd4,  OP_SLTU = 5'd5,  OP_XOR  = 5'd6,  OP_SRL  = 5'd7,
    OP_SRA  = 5'd8,  OP_OR   = 5'd9,  OP_AND  = 5'd10, OP_BEQ  = 5'd11,
    OP_BNE  = 5'd12, OP_BLT  = 5'd13, OP_BGE  = 5'd14, OP_BLTU = 5'd15,
    OP_BGEU = 5'd16, OP_JAL  = 5'd17, OP_JALR = 5'd18
  } op_e;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    op_e               op;
    logic [XLEN-1:0]   opnd1;
    logic [XLEN-1:0]   opnd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   store_data;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic              mem_rd;
    logic              mem_wr;
    logic [F3_W-1:0]   funct3;
    logic              illegal;
  } id_ex_t;

  // Register-index operand with x0, EX, MEM, regfile priority.
  function automatic logic [XLEN-1:0] resolve_opnd(
    input logic [REG_AW-1:0] idx,
    input logic              ex_we,
    input logic [REG_AW-1:0] ex_rd,
    input logic [XLEN-1:0]   ex_data,
    input logic              mem_we,
    input logic [REG_AW-1:0] mem_rd,
    input logic [XLEN-1:0]   mem_data,
    input logic [XLEN-1:0]   rf_data
  );
    if (idx == '0)                     return ZERO_WORD;
    else if (ex_we && ex_rd == idx)    return ex_data;
    else if (mem_we && mem_rd == idx)  return mem_data;
    else                               return rf_data;
  endfunction

  // alt selects SUB (register form only) and SRA.
  function automatic op_e alu_op(input logic [F3_W-1:0] funct3, input logic alt,
                                 input logic is_reg);
    case (funct3)
      3'b000:  return (is_reg && alt) ? OP_SUB : OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return alt ? OP_SRA : OP_SRL;
      3'b110:  return OP_OR;
      3'b111:  return OP_AND;
      default: return OP_NOP;
    endcase
  endfunction

  function automatic op_e branch_op(input logic [F3_W-1:0] funct3);
    case (funct3)
      3'b000:  return OP_BEQ;
      3'b001:  return OP_BNE;
      3'b100:  return OP_BLT;
      3'b101:  return OP_BGE;
      3'b110:  return OP_BLTU;
      3'b111:  return OP_BGEU;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// Immediate generator: selects the I/S/B/U/J immediate by opcode and
// sign-extends it to XLEN.
module id_stage_imm_gen
  import id_stage_pkg::*;
(
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = ZERO_WORD;
    case (inst[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:          imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:         imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm = {inst[31:12], 12'b0};
      OPC_JAL:            imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:            imm = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: regfile read requests, operand forwarding, load-use
// stall and the ID/EX pipeline register.
module id_stage
  import id_stage_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_valid,
  input  logic [XLEN-1:0]   if_pc,
  input  logic [XLEN-1:0]   if_inst,
  output logic              id_ready,
  output logic              read_flag_1,
  output logic [REG_AW-1:0] reg_read_1,
  input  logic [XLEN-1:0]   rf_data_1,
  output logic              read_flag_2,
  output logic [REG_AW-1:0] reg_read_2,
  input  logic [XLEN-1:0]   rf_data_2,
  input  logic              fwd_ex_we,
  input  logic [REG_AW-1:0] fwd_ex_rd,
  input  logic [XLEN-1:0]   fwd_ex_data,
  input  logic              fwd_mem_we,
  input  logic [REG_AW-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0]   fwd_mem_data,
  input  logic              flush_in,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [OP_W-1:0]   ex_op,
  output logic [XLEN-1:0]   ex_opnd1,
  output logic [XLEN-1:0]   ex_opnd2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_rd_we,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic [F3_W-1:0]   ex_funct3,
  output logic              ex_illegal
);

  logic [6:0]        opcode;
  logic [F3_W-1:0]   funct3;
  logic [6:0]        funct7;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;
  logic              uses_rs1;
  logic              uses_rs2;
  logic              writes_rd;
  logic              illegal;
  logic              hazard;
  logic              adv;
  id_ex_t            dec;
  id_ex_t            ex_q;

  assign opcode = if_inst[6:0];
  assign funct3 = if_inst[14:12];
  assign funct7 = if_inst[31:25];
  assign rs1    = if_inst[19:15];
  assign rs2    = if_inst[24:20];
  assign rd     = if_inst[11:7];

  id_stage_imm_gen u_imm_gen (
    .inst (if_inst),
    .imm  (imm)
  );

  assign rs1_val = resolve_opnd(rs1, fwd_ex_we, fwd_ex_rd, fwd_ex_data,
                                fwd_mem_we, fwd_mem_rd, fwd_mem_data, rf_data_1);
  assign rs2_val = resolve_opnd(rs2, fwd_ex_we, fwd_ex_rd, fwd_ex_data,
                                fwd_mem_we, fwd_mem_rd, fwd_mem_data, rf_data_2);

  // Decode into the ID/EX bundle.
  always_comb begin
    uses_rs1       = 1'b0;
    uses_rs2       = 1'b0;
    writes_rd      = 1'b0;
    illegal        = 1'b0;
    dec            = '0;
    dec.valid      = 1'b1;
    dec.pc         = if_pc;
    dec.imm        = imm;
    dec.rd         = rd;
    dec.funct3     = funct3;
    dec.store_data = rs2_val;
    case (opcode)
      OPC_OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
        dec.op    = alu_op(funct3, if_inst[30], 1'b1);
        dec.opnd1 = rs1_val;
        dec.opnd2 = rs2_val;
        illegal   = (funct7 != 7'h00 && funct7 != 7'h20) ||
                    (funct7 == 7'h20 && funct3 != 3'b000 && funct3 != 3'b101);
      end
      OPC_OPIMM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        dec.op    = alu_op(funct3, if_inst[30], 1'b0);
        dec.opnd1 = rs1_val;
        dec.opnd2 = imm;
        illegal   = (funct3 == 3'b001 && funct7 != 7'h00) ||
                    (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20);
      end
      OPC_LOAD: begin
        uses_rs1   = 1'b1;
        writes_rd  = 1'b1;
        dec.op     = OP_ADD;
        dec.mem_rd = 1'b1;
        dec.opnd1  = rs1_val;
        dec.opnd2  = imm;
        illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        dec.op     = OP_ADD;
        dec.mem_wr = 1'b1;
        dec.opnd1  = rs1_val;
        dec.opnd2  = imm;
        illegal    = funct3 > 3'b010;
      end
      OPC_BRANCH: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        dec.op    = branch_op(funct3);
        dec.opnd1 = rs1_val;
        dec.opnd2 = rs2_val;
        illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LUI: begin
        writes_rd = 1'b1;
        dec.op    = OP_ADD;
        dec.opnd2 = imm;
      end
      OPC_AUIPC: begin
        writes_rd = 1'b1;
        dec.op    = OP_ADD;
        dec.opnd1 = if_pc;
        dec.opnd2 = imm;
      end
      OPC_JAL: begin
        writes_rd = 1'b1;
        dec.op    = OP_JAL;
        dec.opnd1 = if_pc;
        dec.opnd2 = XLEN'(4);
      end
      OPC_JALR: begin
        uses_rs1       = 1'b1;
        writes_rd      = 1'b1;
        dec.op         = OP_JALR;
        dec.opnd1      = if_pc;
        dec.opnd2      = XLEN'(4);
        dec.store_data = rs1_val;
        illegal        = funct3 != 3'b000;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      dec.op     = OP_NOP;
      dec.mem_rd = 1'b0;
      dec.mem_wr = 1'b0;
    end
    dec.illegal = illegal;
    dec.rd_we   = writes_rd && (rd != '0) && !illegal;
  end

  assign read_flag_1 = if_valid && uses_rs1;
  assign read_flag_2 = if_valid && uses_rs2;
  assign reg_read_1  = rs1;
  assign reg_read_2  = rs2;

  // A load in EX cannot forward yet; hold the consumer for one bubble.
  assign hazard = ex_q.valid && ex_q.mem_rd && (ex_q.rd != '0) &&
                  ((read_flag_1 && rs1 == ex_q.rd) || (read_flag_2 && rs2 == ex_q.rd));
  assign adv      = rdy_in && (!ex_q.valid || ex_ready);
  assign id_ready = adv && !hazard && !flush_in && !rst_in;

  // ID/EX register; bubbles are all-zero so control bits are always cleared.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ex_q <= '0;
    end else if (rdy_in) begin
      if (flush_in)      ex_q <= '0;
      else if (adv) begin
        if (hazard)        ex_q <= '0;
        else if (if_valid) ex_q <= dec;
        else               ex_q <= '0;
      end
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_op         = ex_q.op;
  assign ex_opnd1      = ex_q.opnd1;
  assign ex_opnd2      = ex_q.opnd2;
  assign ex_imm        = ex_q.imm;
  assign ex_store_data = ex_q.store_data;
  assign ex_rd         = ex_q.rd;
  assign ex_rd_we      = ex_q.rd_we;
  assign ex_mem_rd     = ex_q.mem_rd;
  assign ex_mem_wr     = ex_q.mem_wr;
  assign ex_funct3     = ex_q.funct3;
  assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID/EX bundles are queued when an
// instruction is handed over and compared when it appears on the ex_* side.
module tb_id_stage;
  import id_stage_pkg::*;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              rdy_in = 1'b1;
  logic              if_valid = 1'b0;
  logic [31:0]       if_pc = '0;
  logic [31:0]       if_inst = '0;
  logic              id_ready;
  logic              read_flag_1, read_flag_2;
  logic [4:0]        reg_read_1, reg_read_2;
  logic [31:0]       rf_data_1 = '0, rf_data_2 = '0;
  logic              fwd_ex_we = 1'b0, fwd_mem_we = 1'b0;
  logic [4:0]        fwd_ex_rd = '0, fwd_mem_rd = '0;
  logic [31:0]       fwd_ex_data = '0, fwd_mem_data = '0;
  logic              flush_in = 1'b0;
  logic              ex_ready = 1'b1;
  logic              ex_valid;
  logic [31:0]       ex_pc, ex_opnd1, ex_opnd2, ex_imm, ex_store_data;
  logic [4:0]        ex_op, ex_rd;
  logic              ex_rd_we, ex_mem_rd, ex_mem_wr, ex_illegal;
  logic [2:0]        ex_funct3;

  int n_checks = 0;
  int n_fail   = 0;

  // Mask bits select which unspecified-for-some-formats fields are compared.
  localparam logic [4:0] M_OPND = 5'b00001;
  localparam logic [4:0] M_IMM  = 5'b00010;
  localparam logic [4:0] M_SD   = 5'b00100;
  localparam logic [4:0] M_RD   = 5'b01000;
  localparam logic [4:0] M_F3   = 5'b10000;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  op;
    logic [31:0] o1, o2, imm, sd;
    logic [4:0]  rd;
    logic        we, mrd, mwr, ill;
    logic [2:0]  f3;
    logic [4:0]  mask;
  } exp_t;

  exp_t sb[$];

  id_stage dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .id_ready(id_ready),
    .read_flag_1(read_flag_1), .reg_read_1(reg_read_1), .rf_data_1(rf_data_1),
    .read_flag_2(read_flag_2), .reg_read_2(reg_read_2), .rf_data_2(rf_data_2),
    .fwd_ex_we(fwd_ex_we), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .flush_in(flush_in), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_op(ex_op), .ex_opnd1(ex_opnd1), .ex_opnd2(ex_opnd2), .ex_imm(ex_imm),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_funct3(ex_funct3),
    .ex_illegal(ex_illegal)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
  endtask

  task automatic expect_bundle(input logic [31:0] pc, input op_e op,
                               input logic [31:0] o1, input logic [31:0] o2,
                               input logic [31:0] imm, input logic [31:0] sd,
                               input logic [4:0] rd, input logic we, input logic mrd,
                               input logic mwr, input logic ill, input logic [2:0] f3,
                               input logic [4:0] mask);
    exp_t e;
    e.pc = pc; e.op = op; e.o1 = o1; e.o2 = o2; e.imm = imm; e.sd = sd;
    e.rd = rd; e.we = we; e.mrd = mrd; e.mwr = mwr; e.ill = ill; e.f3 = f3;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, ".sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".valid"},   32'(ex_valid),   32'd1);
      chk({tag, ".pc"},      ex_pc,           e.pc);
      chk({tag, ".op"},      32'(ex_op),      32'(e.op));
      chk({tag, ".rd_we"},   32'(ex_rd_we),   32'(e.we));
      chk({tag, ".mem_rd"},  32'(ex_mem_rd),  32'(e.mrd));
      chk({tag, ".mem_wr"},  32'(ex_mem_wr),  32'(e.mwr));
      chk({tag, ".illegal"}, 32'(ex_illegal), 32'(e.ill));
      if ((e.mask & M_OPND) != 0) begin
        chk({tag, ".opnd1"}, ex_opnd1, e.o1);
        chk({tag, ".opnd2"}, ex_opnd2, e.o2);
      end
      if ((e.mask & M_IMM) != 0) chk({tag, ".imm"},    ex_imm,           e.imm);
      if ((e.mask & M_SD)  != 0) chk({tag, ".sdata"},  ex_store_data,    e.sd);
      if ((e.mask & M_RD)  != 0) chk({tag, ".rd"},     32'(ex_rd),       32'(e.rd));
      if ((e.mask & M_F3)  != 0) chk({tag, ".funct3"}, 32'(ex_funct3),   32'(e.f3));
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst.valid", 32'(ex_valid), 32'd0);
    chk("rst.op", 32'(ex_op), 32'(OP_NOP));
    chk("rst.rd_we", 32'(ex_rd_we), 32'd0);
    chk("rst.pc", ex_pc, 32'd0);
    chk("rst.id_ready", 32'(id_ready), 32'd0);
    rst_in = 1'b0;

    // addi x1,x0,5 -- x0 reads as zero even with nonzero regfile data
    rf_data_1 = 32'h1111;
    drive(1'b1, 32'h0, 32'h00500093);
    #1;
    chk("addi.id_ready", 32'(id_ready), 32'd1);
    chk("addi.rf1", 32'(read_flag_1), 32'd1);
    chk("addi.rs1", 32'(reg_read_1), 32'd0);
    chk("addi.rf2", 32'(read_flag_2), 32'd0);
    expect_bundle(32'h0, OP_ADD, 32'd0, 32'd5, 32'd5, 32'd0, 5'd1, 1, 0, 0, 0, 3'd0,
                  M_OPND | M_IMM | M_RD | M_F3);
    tick(); pop_check("addi");

    // lui x5,0x12345
    drive(1'b1, 32'h4, 32'h123452B7);
    #1;
    chk("lui.rf1", 32'(read_flag_1), 32'd0);
    expect_bundle(32'h4, OP_ADD, 32'd0, 32'h12345000, 32'h12345000, 32'd0, 5'd5, 1, 0, 0, 0,
                  3'd0, M_OPND | M_IMM | M_RD);
    tick(); pop_check("lui");

    // add x3,x1,x1 -- EX wins over MEM
    fwd_ex_we = 1; fwd_ex_rd = 5'd1; fwd_ex_data = 32'd5;
    fwd_mem_we = 1; fwd_mem_rd = 5'd1; fwd_mem_data = 32'd9;
    rf_data_1 = 32'h77; rf_data_2 = 32'h88;
    drive(1'b1, 32'h8, 32'h001081B3);
    #1;
    expect_bundle(32'h8, OP_ADD, 32'd5, 32'd5, 32'd0, 32'd0, 5'd3, 1, 0, 0, 0, 3'd0,
                  M_OPND | M_RD | M_F3);
    tick(); pop_check("add_fwd_ex");

    // add x3,x1,x2 -- EX forward disabled, MEM forwards rs2, rs1 from regfile
    fwd_ex_we = 0; fwd_mem_rd = 5'd2;
    drive(1'b1, 32'hC, 32'h002081B3);
    #1;
    expect_bundle(32'hC, OP_ADD, 32'h77, 32'd9, 32'd0, 32'd0, 5'd3, 1, 0, 0, 0, 3'd0,
                  M_OPND | M_RD);
    tick(); pop_check("add_fwd_mem");

    // lw x2,0(x1) then add x3,x2,x2: one bubble, then MEM forwarding
    fwd_mem_we = 0; rf_data_1 = 32'h100; rf_data_2 = 32'h0;
    drive(1'b1, 32'h10, 32'h0000A103);
    #1;
    expect_bundle(32'h10, OP_ADD, 32'h100, 32'd0, 32'd0, 32'd0, 5'd2, 1, 1, 0, 0, 3'd2,
                  M_OPND | M_IMM | M_RD | M_F3);
    tick(); pop_check("lw");
    drive(1'b1, 32'h14, 32'h002101B3);
    #1;
    chk("lu.id_ready_stall", 32'(id_ready), 32'd0);
    tick();
    chk("lu.bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu.bubble_mem_rd", 32'(ex_mem_rd), 32'd0);
    chk("lu.bubble_rd_we", 32'(ex_rd_we), 32'd0);
    fwd_mem_we = 1; fwd_mem_rd = 5'd2; fwd_mem_data = 32'hDEADBEEF;
    #1;
    chk("lu.id_ready_resume", 32'(id_ready), 32'd1);
    expect_bundle(32'h14, OP_ADD, 32'hDEADBEEF, 32'hDEADBEEF, 32'd0, 32'd0, 5'd3, 1, 0, 0, 0,
                  3'd0, M_OPND | M_RD);
    tick(); pop_check("lu_add");
    fwd_mem_we = 0;

    // Back-pressure: ex_ready low 3 cycles, then rdy_in low 2 cycles
    drive(1'b1, 32'h18, 32'h00700213);
    #1;
    expect_bundle(32'h18, OP_ADD, 32'd0, 32'd7, 32'd7, 32'd0, 5'd4, 1, 0, 0, 0, 3'd0,
                  M_OPND | M_IMM | M_RD);
    tick(); pop_check("addi_x4");
    ex_ready = 0;
    drive(1'b1, 32'h1C, 32'h0F006313);
    #1;
    chk("stall.id_ready0", 32'(id_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin ex_ready = 1; rdy_in = 0; end
      tick();
      chk("hold.valid", 32'(ex_valid), 32'd1);
      chk("hold.pc", ex_pc, 32'h18);
      chk("hold.opnd2", ex_opnd2, 32'd7);
      chk("hold.rd", 32'(ex_rd), 32'd4);
      chk("hold.id_ready", 32'(id_ready), 32'd0);
    end
    rdy_in = 1;
    #1;
    chk("resume.id_ready", 32'(id_ready), 32'd1);
    expect_bundle(32'h1C, OP_OR, 32'd0, 32'hF0, 32'hF0, 32'd0, 5'd6, 1, 0, 0, 0, 3'd6,
                  M_OPND | M_IMM | M_RD | M_F3);
    tick(); pop_check("ori");

    // Flush during a load-use stall, then an illegal word from the new path
    rf_data_1 = 32'h200;
    drive(1'b1, 32'h20, 32'h0040A103);
    #1;
    expect_bundle(32'h20, OP_ADD, 32'h200, 32'd4, 32'd4, 32'd0, 5'd2, 1, 1, 0, 0, 3'd2,
                  M_OPND | M_IMM | M_RD | M_F3);
    tick(); pop_check("lw2");
    drive(1'b1, 32'h24, 32'h002101B3);
    flush_in = 1;
    #1;
    chk("flush.id_ready", 32'(id_ready), 32'd0);
    tick();
    chk("flush.valid", 32'(ex_valid), 32'd0);
    chk("flush.mem_rd", 32'(ex_mem_rd), 32'd0);
    flush_in = 0;
    drive(1'b1, 32'h40, 32'hFFFFFFFF);
    #1;
    chk("ill.id_ready", 32'(id_ready), 32'd1);
    chk("ill.rf1", 32'(read_flag_1), 32'd0);
    expect_bundle(32'h40, OP_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 1, 3'd0, 5'd0);
    tick(); pop_check("illegal");
    drive(1'b0, 32'h44, 32'h0);
    tick();
    chk("idle.valid", 32'(ex_valid), 32'd0);

    // sw x2,8(x1)
    rf_data_1 = 32'h300; rf_data_2 = 32'h55;
    drive(1'b1, 32'h48, 32'h0020A423);
    #1;
    chk("sw.rf2", 32'(read_flag_2), 32'd1);
    chk("sw.rs2", 32'(reg_read_2), 32'd2);
    expect_bundle(32'h48, OP_ADD, 32'h300, 32'd8, 32'd8, 32'h55, 5'd0, 0, 0, 1, 0, 3'd2,
                  M_OPND | M_IMM | M_SD | M_F3);
    tick(); pop_check("sw");

    // beq x1,x2,-8
    drive(1'b1, 32'h50, 32'hFE208CE3);
    #1;
    expect_bundle(32'h50, OP_BEQ, 32'h300, 32'h55, 32'hFFFFFFF8, 32'h55, 5'd0, 0, 0, 0, 0,
                  3'd0, M_OPND | M_IMM | M_SD | M_F3);
    tick(); pop_check("beq");

    // jal x1,+16
    drive(1'b1, 32'h54, 32'h010000EF);
    #1;
    chk("jal.rf1", 32'(read_flag_1), 32'd0);
    expect_bundle(32'h54, OP_JAL, 32'h54, 32'd4, 32'd16, 32'd0, 5'd1, 1, 0, 0, 0, 3'd0,
                  M_OPND | M_IMM | M_RD);
    tick(); pop_check("jal");

    // Async reset mid-cycle with a live bundle
    drive(1'b1, 32'h60, 32'h00500093);
    #1;
    expect_bundle(32'h60, OP_ADD, 32'd0, 32'd5, 32'd5, 32'd0, 5'd1, 1, 0, 0, 0, 3'd0,
                  M_OPND | M_RD);
    tick(); pop_check("addi_pre_rst");
    drive(1'b0, 32'h0, 32'h0);
    #2;
    rst_in = 1;
    #1;
    chk("arst.valid", 32'(ex_valid), 32'd0);
    chk("arst.op", 32'(ex_op), 32'(OP_NOP));
    chk("arst.rd_we", 32'(ex_rd_we), 32'd0);
    chk("arst.opnd2", ex_opnd2, 32'd0);
    chk("arst.pc", ex_pc, 32'd0);
    chk("arst.id_ready", 32'(id_ready), 32'd0);
    chk("sb.drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
